neuron_ram_burst_reader: RTL and testbench

//  Read-side engine for the neuron dual-port weight RAM. On a start pulse it issues a burst
//  of sequential reads on the RAM read port (read_address/oe) and streams the returned bytes
//  to a downstream consumer (MAC/neuron datapath) over a valid/ready handshake.
//  The RAM write port stays with the weight loader; this block never drives write_address/wre.

---
 rtl/neuron_ram_burst_reader.sv | 101 ++++++++++
 tb/tb_neuron_ram_burst_reader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/neuron_ram_burst_reader.sv
// neuron_ram_burst_reader: burst read engine from the weight RAM read port to a valid/ready stream.
// Optional running checksum of streamed bytes when NEURON_READER_CHECKSUM_EN is defined.
module neuron_ram_burst_reader #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_read_address,
  output logic              ram_oe,
  input  logic [DATA_W-1:0] ram_read_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
`ifdef NEURON_READER_CHECKSUM_EN
  ,
  output logic [DATA_W+ADDR_W-1:0] checksum
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t state, state_n;
  logic [ADDR_W:0] remaining;
  logic [ADDR_W-1:0] next_addr, last_addr;
  logic pend, pend_last, issue, pop, accept, fin, last_issue;
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic mem_l [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] count;
  assign busy = state != IDLE;
  assign accept = start && state == IDLE;
  assign m_valid = count != '0;
  assign m_data = mem_d[rp];
  assign m_last = m_valid && mem_l[rp];
  assign pop = m_valid && m_ready;
  assign fin = pop && m_last;
  // Credit counts the word leaving this cycle so a full pipeline sustains one word per cycle.
  assign issue = state == READ && (count + CW'(pend) - CW'(pop)) < CW'(FIFO_DEPTH);
  assign last_issue = issue && remaining == (ADDR_W+1)'(1);
  assign ram_oe = issue;
  assign ram_read_address = issue ? next_addr : last_addr;
  always_comb begin
    state_n = state;
    if (state == IDLE && start && length != '0) state_n = READ;
    if (state == READ && last_issue) state_n = DRAIN;
    if (state == DRAIN && fin) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done <= 1'b0;
      remaining <= '0;
      next_addr <= '0;
      last_addr <= '0;
      pend <= 1'b0;
      pend_last <= 1'b0;
      wp <= '0;
      rp <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_d[i] <= '0;
        mem_l[i] <= 1'b0;
      end
    end else begin
      state <= state_n;
      done <= (accept && length == '0) || fin;
      if (accept) begin
        next_addr <= base_addr;
        remaining <= length;
      end else if (issue) begin
        next_addr <= next_addr + ADDR_W'(1);
        last_addr <= next_addr;
        remaining <= remaining - (ADDR_W+1)'(1);
      end
      pend <= issue;
      pend_last <= last_issue;
      if (pend) begin
        mem_d[wp] <= ram_read_data;
        mem_l[wp] <= pend_last;
        wp <= wp + PW'(1);
      end
      if (pop) rp <= rp + PW'(1);
      count <= count + CW'(pend) - CW'(pop);
    end
  end
`ifdef NEURON_READER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) checksum <= '0;
    else if (accept) checksum <= '0;
    else if (pop) checksum <= checksum + (DATA_W+ADDR_W)'(m_data);
  end
`endif
endmodule

// File: tb/tb_neuron_ram_burst_reader.sv
// tb_neuron_ram_burst_reader: scoreboard bench for the burst reader against a 1-cycle RAM model.
module tb_neuron_ram_burst_reader;
  localparam int D = 2;
  logic clk = 0, rst_n = 0, start = 0, m_ready = 0;
  logic [7:0] base_addr = 0;
  logic [8:0] length = 0;
  logic busy, done, ram_oe, m_valid, m_last;
  logic [7:0] ram_read_address, ram_read_data, m_data;
`ifdef NEURON_READER_CHECKSUM_EN
  logic [15:0] checksum;
`endif
  logic [7:0] ram [256];
  logic [8:0] sb_q [$];
  logic [7:0] addr_q [$];
  int errors = 0, checks = 0;

  neuron_ram_burst_reader #(.DATA_W(8), .ADDR_W(8), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .ram_read_address(ram_read_address), .ram_oe(ram_oe),
    .ram_read_data(ram_read_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last)
`ifdef NEURON_READER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (ram_oe) ram_read_data <= ram[ram_read_address];

  task automatic run_burst(input logic [7:0] base, input logic [8:0] len, input int mode, input bit poke);
    int cyc, issued, popped, dones, first_v;
    logic stall, fin;
    logic [8:0] held, exp;
    logic [15:0] sum;
    logic [7:0] a;
    sum = 0;
    for (int k = 0; k < len; k++) begin
      a = base + k[7:0];
      addr_q.push_back(a);
      sb_q.push_back({ram[a], k == len - 1});
      sum += 16'(ram[a]);
    end
    @(negedge clk);
    start = 1; base_addr = base; length = len;
    cyc = 0; issued = 0; popped = 0; dones = 0; first_v = -1; stall = 0; fin = 0; held = 0;
    while (!fin && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = poke && cyc == 4;
      if (start) begin base_addr = 8'h55; length = 9'd3; end
      m_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 1) : 1'($urandom_range(0, 1));
      #1;
      if (stall) begin
        checks++;
        if (!m_valid || {m_data, m_last} !== held) begin
          errors++;
          $display("FAIL stall_hold cyc=%0d valid=%b data/last=%h required valid=1 data/last=%h", cyc, m_valid, {m_data, m_last}, held);
        end
      end
      if (m_valid && first_v < 0) first_v = cyc;
      if (mode == 0 && first_v >= 0 && popped < len) begin
        checks++;
        if (m_valid !== 1'b1) begin errors++; $display("FAIL no_bubble cyc=%0d valid=%b required 1", cyc, m_valid); end
      end
      if (ram_oe) begin
        issued++;
        checks++;
        if (addr_q.size() == 0 || ram_read_address !== addr_q[0]) begin
          errors++;
          $display("FAIL read_addr cyc=%0d addr=%h required %h (queue %0d)", cyc, ram_read_address, addr_q.size() ? addr_q[0] : 8'hxx, addr_q.size());
        end
        if (addr_q.size()) void'(addr_q.pop_front());
      end
      if (m_valid && m_ready) begin
        popped++;
        checks++;
        exp = sb_q.size() ? sb_q.pop_front() : 9'hxxx;
        if ({m_data, m_last} !== exp) begin
          errors++;
          $display("FAIL stream cyc=%0d data=%h last=%b required data=%h last=%b", cyc, m_data, m_last, exp[8:1], exp[0]);
        end
      end
      if (ram_oe) begin
        checks++;
        if (issued - popped > D) begin errors++; $display("FAIL read_ahead cyc=%0d ahead=%0d required <=%0d", cyc, issued - popped, D); end
      end
      stall = m_valid && !m_ready;
      held = {m_data, m_last};
`ifdef NEURON_READER_CHECKSUM_EN
      if (cyc == 1) begin
        checks++;
        if (checksum !== 16'd0) begin errors++; $display("FAIL checksum_clear got %0d required 0", checksum); end
      end
`endif
      if (done) begin
        dones++;
        fin = 1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done got %b required 0", busy); end
      end
    end
    start = 0;
    checks++;
    if (!fin) begin errors++; $display("FAIL timeout base=%h len=%0d got no done required done", base, len); end
    checks++;
    if (issued != len || popped != len || sb_q.size() || addr_q.size()) begin
      errors++;
      $display("FAIL counts issued=%0d popped=%0d left=%0d/%0d required %0d/%0d/0/0", issued, popped, sb_q.size(), addr_q.size(), len, len);
    end
    if (mode == 0) begin
      checks++;
      if (first_v != 3) begin errors++; $display("FAIL first_latency cyc=%0d required 3", first_v); end
    end
`ifdef NEURON_READER_CHECKSUM_EN
    checks++;
    if (checksum !== sum) begin errors++; $display("FAIL checksum got %0d required %0d", checksum, sum); end
`endif
    sb_q.delete();
    addr_q.delete();
    @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL done_once done=%b busy=%b required 0 0", done, busy); end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({busy, done, ram_oe, m_valid, m_last, ram_read_address, m_data} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b %b %b %b %b %h %h required all 0", busy, done, ram_oe, m_valid, m_last, ram_read_address, m_data);
    end
  endtask

  task automatic test_zero_length;
    @(negedge clk);
    start = 1; base_addr = 8'h40; length = 0;
    @(negedge clk);
    start = 0;
    #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || ram_oe !== 1'b0) begin
      errors++;
      $display("FAIL zero_len done=%b busy=%b oe=%b required 1 0 0", done, busy, ram_oe);
    end
    @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || ram_oe !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_after done=%b busy=%b oe=%b required 0 0 0", done, busy, ram_oe);
    end
  endtask

  task automatic test_reset_mid;
    int popped, cyc;
    @(negedge clk);
    start = 1; base_addr = 8'h10; length = 8; m_ready = 1;
    popped = 0; cyc = 0;
    while (popped < 2 && cyc < 50) begin
      @(negedge clk);
      start = 0;
      cyc++;
      #1;
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== ram[8'h10 + popped[7:0]]) begin
          errors++;
          $display("FAIL mid_stream idx=%0d data=%h required %h", popped, m_data, ram[8'h10 + popped[7:0]]);
        end
        popped++;
      end
    end
    rst_n = 0;
    #1;
    checks++;
    if ({busy, done, ram_oe, m_valid, m_last, ram_read_address, m_data} !== 21'd0) begin
      errors++;
      $display("FAIL async_reset got %b %b %b %b %b %h %h required all 0", busy, done, ram_oe, m_valid, m_last, ram_read_address, m_data);
    end
    @(negedge clk);
    rst_n = 1;
    run_burst(8'h10, 9'd8, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i + 3);
    repeat (2) @(negedge clk);
    test_reset;
    rst_n = 1;
    run_burst(8'h00, 9'd4, 0, 0);
    run_burst(8'hFE, 9'd4, 0, 0);
    run_burst(8'h20, 9'd8, 1, 1);
    test_zero_length;
    run_burst(8'h80, 9'd256, 0, 0);
    run_burst(8'h33, 9'd13, 2, 0);
    test_reset_mid;
    ram[0] = 10; ram[1] = 20; ram[2] = 30; ram[3] = 40;
    run_burst(8'h00, 9'd4, 0, 0);
    run_burst(8'h00, 9'd2, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
